binary_to_bcd_seq: RTL

Parametrised, multi-cycle binary-to-BCD converter that uses the shift-and-add-3 (double-dabble) algorithm. It replaces fixed-width lookup conversion in the display and reporting datapaths. A valid/ready handshake sits on both the input and output sides, and the block converts one value per transaction. Hardware cost is one DIGITS-wide add-3 stage, shared across WIDTH clock cycles.

---
 rtl/binary_to_bcd_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/binary_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// binary_to_bcd_seq
//
// Multi-cycle binary-to-BCD converter using the shift-and-add-3
// (double-dabble) algorithm. A single DIGITS-wide add-3 stage is reused over
// WIDTH clock cycles, one shift step per cycle. A valid/ready handshake is
// used on both the input and the output side, and one value is converted per
// transaction.
//
// Parameters:
//   WIDTH  - binary input width, 1..32
//   DIGITS - number of BCD output digits; 10^DIGITS must exceed 2^WIDTH-1
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   in_valid   in   binary holds a value to convert
//   in_ready   out  block can accept a value (high only while idle)
//   binary     in   unsigned value, sampled only on the input handshake
//   out_valid  out  bcd holds a completed result
//   out_ready  in   downstream accepts the result
//   bcd        out  packed BCD result, digit k at [4k+3:4k], digit 0 is LSD
// -----------------------------------------------------------------------------
module binary_to_bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    binary,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] bcd
);

   localparam int BCD_W  = 4 * DIGITS;
   localparam int WORD_W = BCD_W + WIDTH;
   localparam int CNT_W  = $clog2(WIDTH + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // ---------------------------------------------------------------------------
   // Parameter legality: the digit count must be able to hold the largest
   // binary value. The power of ten is capped once it is already far beyond
   // any 32-bit value so the 64-bit product cannot wrap.
   // ---------------------------------------------------------------------------
   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 64'd1;
      for (int i = 0; (i < n) && (i < 12); i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

   localparam longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1;
   localparam bit              PARAMS_OK = (WIDTH >= 1) && (WIDTH <= 32) &&
                                           (DIGITS >= 1) &&
                                           (pow10(DIGITS) > MAX_VAL);

   generate
      if (!PARAMS_OK) begin : g_param_check
         $error("binary_to_bcd_seq: illegal WIDTH/DIGITS combination");
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Add-3 correction: every digit that is 5 or more gets +3 so that the
   // following left shift carries correctly into the next decimal digit. The
   // add is 4 bits wide; a corrected digit (8..12) never overflows 4 bits.
   // ---------------------------------------------------------------------------
   function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] acc);
      logic [BCD_W-1:0] r;
      logic [3:0]       d;
      r = acc;
      for (int k = 0; k < DIGITS; k++) begin
         d = acc[4*k +: 4];
         if (d >= 4'd5) begin
            r[4*k +: 4] = d + 4'd3;
         end
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sreg_q,  sreg_d;    // binary bits still to be shifted in
   logic [BCD_W-1:0] acc_q,   acc_d;     // BCD accumulator, internal only
   logic [CNT_W-1:0] cnt_q,   cnt_d;     // remaining shift steps
   logic [BCD_W-1:0] bcd_q,   bcd_d;     // result visible on the port

   // One double-dabble step: correct, then shift {acc, sreg} left by one so
   // the binary MSB enters digit 0 bit 0.
   logic [WORD_W-1:0] step_word;
   logic [BCD_W-1:0]  step_acc;
   logic [WIDTH-1:0]  step_sreg;

   always_comb begin
      step_word = {add3_digits(acc_q), sreg_q} << 1;
      step_acc  = step_word[WORD_W-1:WIDTH];
      step_sreg = step_word[WIDTH-1:0];
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               sreg_d  = binary;
               acc_d   = '0;
               cnt_d   = CNT_W'(WIDTH);
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            acc_d  = step_acc;
            sreg_d = step_sreg;
            cnt_d  = cnt_q - CNT_W'(1);
            // The port result is updated only on the last step so partial
            // accumulator values are never visible outside.
            if (cnt_q == CNT_W'(1)) begin
               bcd_d   = step_acc;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sreg_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
      end
   end

   // Handshake outputs come straight from the registered state, so there is
   // no combinational path from in_valid or out_ready.
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign bcd       = bcd_q;

endmodule
